// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the WISC pipeline hazard scoreboard.
// Entries carry a fixed-width rd field so the struct can live in a package; NUM_REGS must not exceed 2**MAX_RW.
package wisc_pipe_pkg;

  localparam int MAX_RW      = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic              valid;
    logic [MAX_RW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } sb_entry_t;

  function automatic int fwd_sel_w(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the ID stage and the hazard scoreboard.
interface hazard_scoreboard_if
  import wisc_pipe_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int STAGES   = 3,
  parameter int CNT_W    = 16
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int SW = fwd_sel_w(STAGES);

  // id_valid marks a real decode instruction; hazard is the inverse of ready:
  // the instruction is accepted on a cycle with id_valid & ~hazard & ~flush.
  logic          id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          id_rs_used;
  logic          id_rt_used;
  logic [RW-1:0] id_rd;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          flush;
  logic             hazard;
  logic [SW-1:0]    fwd_rs_sel;
  logic [SW-1:0]    fwd_rt_sel;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
           id_reg_write, id_mem_read, flush,
    input  hazard, fwd_rs_sel, fwd_rt_sel, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
           id_reg_write, id_mem_read, flush,
    output hazard, fwd_rs_sel, fwd_rt_sel, stall_count
  );

endinterface

// File: rtl/hazard_scoreboard_sb_match.sv
// Finds the youngest in-flight entry that writes a given source register.
module sb_match
  import wisc_pipe_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int ZERO_REG = 1,
  parameter int IDX_W    = 2
) (
  input  logic [MAX_RW-1:0]      i_src,
  input  logic                   i_used,
  input  sb_entry_t [STAGES-1:0] i_entries,
  output logic                   o_any_match,
  output logic [IDX_W-1:0]       o_youngest_idx,
  output logic                   o_youngest_is_load
);

  logic w_src_live;

  assign w_src_live = i_used & ~((ZERO_REG != 0) & (i_src == '0));

  // Walk oldest to youngest so the youngest match is the last one written.
  always_comb begin
    o_any_match        = 1'b0;
    o_youngest_idx     = '0;
    o_youngest_is_load = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (w_src_live && i_entries[k].valid && i_entries[k].reg_write &&
          (i_entries[k].rd == i_src)) begin
        o_any_match        = 1'b1;
        o_youngest_idx     = IDX_W'(k);
        o_youngest_is_load = i_entries[k].mem_read;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard and forwarding controller: shift scoreboard of in-flight
// destinations, stall request, per-operand forward selects, saturating stall counter.
module hazard_scoreboard
  import wisc_pipe_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int STAGES   = 3,
  parameter int FWD_EN   = 1,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_scoreboard_if.slave bus
);

  localparam int SW = fwd_sel_w(STAGES);

  sb_entry_t [STAGES-1:0] r_entries;
  logic [CNT_W-1:0]       r_stall_count;
  sb_entry_t              w_new_entry;
  logic                   w_live;
  logic                   w_hazard;
  logic                   w_rs_any, w_rs_load, w_rt_any, w_rt_load;
  logic [SW-1:0]          w_rs_idx, w_rt_idx;
  logic                   w_stall_fwd, w_stall_all;

  sb_match #(.STAGES(STAGES), .ZERO_REG(ZERO_REG), .IDX_W(SW)) u_match_rs (
    .i_src              (MAX_RW'(bus.id_rs)),
    .i_used             (bus.id_rs_used),
    .i_entries          (r_entries),
    .o_any_match        (w_rs_any),
    .o_youngest_idx     (w_rs_idx),
    .o_youngest_is_load (w_rs_load)
  );

  sb_match #(.STAGES(STAGES), .ZERO_REG(ZERO_REG), .IDX_W(SW)) u_match_rt (
    .i_src              (MAX_RW'(bus.id_rt)),
    .i_used             (bus.id_rt_used),
    .i_entries          (r_entries),
    .o_any_match        (w_rt_any),
    .o_youngest_idx     (w_rt_idx),
    .o_youngest_is_load (w_rt_load)
  );

  assign w_live = bus.id_valid & ~bus.flush;

  // With forwarding only a load sitting in ID/EX cannot be bypassed in time.
  assign w_stall_fwd = (w_rs_any & w_rs_load & (w_rs_idx == '0)) |
                       (w_rt_any & w_rt_load & (w_rt_idx == '0));
  assign w_stall_all = w_rs_any | w_rt_any;
  assign w_hazard    = ~rst & w_live & ((FWD_EN != 0) ? w_stall_fwd : w_stall_all);

  assign bus.hazard      = w_hazard;
  assign bus.fwd_rs_sel  = (FWD_EN != 0 && w_rs_any && !rst) ? w_rs_idx + SW'(1) : SW'(FWD_REGFILE);
  assign bus.fwd_rt_sel  = (FWD_EN != 0 && w_rt_any && !rst) ? w_rt_idx + SW'(1) : SW'(FWD_REGFILE);
  assign bus.stall_count = r_stall_count;

  always_comb begin
    w_new_entry = '0;
    if (w_live && !w_hazard) begin
      w_new_entry.valid     = 1'b1;
      w_new_entry.rd        = MAX_RW'(bus.id_rd);
      w_new_entry.reg_write = bus.id_reg_write;
      w_new_entry.mem_read  = bus.id_mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_entries     <= '0;
      r_stall_count <= '0;
    end else begin
      for (int k = 1; k < STAGES; k++) begin
        r_entries[k] <= r_entries[k-1];
      end
      r_entries[0] <= w_new_entry;
      if (w_hazard && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding, stall-only and narrow-counter instances.
module tb_hazard_scoreboard;

  typedef struct packed {
    logic       valid;
    logic [3:0] rs;
    logic       rs_used;
    logic [3:0] rt;
    logic       rt_used;
    logic [3:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       flush;
  } stim_t;

  logic        clk;
  logic        rst;
  stim_t       stim        [3];
  logic        obs_hazard  [3];
  logic [1:0]  obs_rs      [3];
  logic [1:0]  obs_rt      [3];
  logic [15:0] obs_cnt     [3];
  logic [20:0] exp_q[$];
  int          checks;
  int          errors;
  stim_t       tmp;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instance 0: forwarding; 1: stall-only; 2: forwarding with a 2-bit counter
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int P_FWD = (g == 1) ? 0 : 1;
    localparam int P_CNT = (g == 2) ? 2 : 16;

    hazard_scoreboard_if #(.NUM_REGS(16), .STAGES(3), .CNT_W(P_CNT)) bus ();

    assign bus.id_valid     = stim[g].valid;
    assign bus.id_rs        = stim[g].rs;
    assign bus.id_rt        = stim[g].rt;
    assign bus.id_rs_used   = stim[g].rs_used;
    assign bus.id_rt_used   = stim[g].rt_used;
    assign bus.id_rd        = stim[g].rd;
    assign bus.id_reg_write = stim[g].reg_write;
    assign bus.id_mem_read  = stim[g].mem_read;
    assign bus.flush        = stim[g].flush;

    hazard_scoreboard #(
      .NUM_REGS(16), .STAGES(3), .FWD_EN(P_FWD), .ZERO_REG(1), .CNT_W(P_CNT)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign obs_hazard[g] = bus.hazard;
    assign obs_rs[g]     = bus.fwd_rs_sel;
    assign obs_rt[g]     = bus.fwd_rt_sel;
    assign obs_cnt[g]    = 16'(bus.stall_count);
  end

  function automatic stim_t mk(input logic [3:0] rs, input logic rs_u,
                               input logic [3:0] rt, input logic rt_u,
                               input logic [3:0] rd, input logic rw, input logic ld);
    stim_t s;
    s           = '0;
    s.valid     = 1'b1;
    s.rs        = rs;
    s.rs_used   = rs_u;
    s.rt        = rt;
    s.rt_used   = rt_u;
    s.rd        = rd;
    s.reg_write = rw;
    s.mem_read  = ld;
    return s;
  endfunction

  // driver + scoreboard: drive one instance for a cycle, queue the expectation,
  // pop and compare it at the falling edge
  task automatic step(input int d, input stim_t s, input string tag,
                      input logic h, input logic [1:0] ers, input logic [1:0] ert,
                      input logic [15:0] ec);
    logic [20:0] exp_v;
    logic [20:0] obs_v;
    for (int i = 0; i < 3; i++) stim[i] = '0;
    stim[d] = s;
    exp_q.push_back({h, ers, ert, ec});
    @(negedge clk);
    exp_v = exp_q.pop_front();
    obs_v = {obs_hazard[d], obs_rs[d], obs_rt[d], obs_cnt[d]};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed hazard=%0b rs_sel=%0d rt_sel=%0d cnt=%0d, expected hazard=%0b rs_sel=%0d rt_sel=%0d cnt=%0d",
             tag, obs_v[20], obs_v[19:18], obs_v[17:16], obs_v[15:0],
             exp_v[20], exp_v[19:18], exp_v[17:16], exp_v[15:0]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    for (int i = 0; i < 3; i++) stim[i] = '0;
    @(posedge clk);
    #1;

    // reset state of every instance, with a reader presented
    step(0, mk(4'd3, 1, 4'd3, 1, 4'd0, 0, 0), "rst_fwd",   0, 0, 0, 0);
    step(1, mk(4'd3, 1, 4'd3, 1, 4'd0, 0, 0), "rst_stall", 0, 0, 0, 0);
    step(2, mk(4'd3, 1, 4'd3, 1, 4'd0, 0, 0), "rst_sat",   0, 0, 0, 0);
    rst = 1'b0;

    // ALU forwarding from entry 0 then entry 1
    step(0, mk(4'd0, 0, 4'd0, 0, 4'd3, 1, 0), "add_r3",    0, 0, 0, 0);
    step(0, mk(4'd3, 1, 4'd0, 0, 4'd6, 1, 0), "sub_fwd1",  0, 1, 0, 0);
    step(0, mk(4'd3, 1, 4'd0, 0, 4'd7, 0, 0), "rd_fwd2",   0, 2, 0, 0);

    // load-use: one stall then forward from entry 1
    step(0, mk(4'd0, 0, 4'd0, 0, 4'd5, 1, 1), "lw_r5",     0, 0, 0, 0);
    step(0, mk(4'd0, 0, 4'd5, 1, 4'd0, 0, 0), "ld_use",    1, 0, 1, 0);
    step(0, mk(4'd0, 0, 4'd5, 1, 4'd0, 0, 0), "ld_retry",  0, 0, 2, 1);

    // register 0 never hazards or forwards, even from a load
    step(0, mk(4'd0, 0, 4'd0, 0, 4'd0, 1, 1), "lw_r0",     0, 0, 0, 1);
    step(0, mk(4'd0, 1, 4'd0, 1, 4'd0, 0, 0), "rd_r0",     0, 0, 0, 1);

    // R4 written at entries 0 and 2: youngest wins; unused source ignored
    step(0, mk(4'd0, 0, 4'd0, 0, 4'd4, 1, 0), "w_r4_a",    0, 0, 0, 1);
    step(0, mk(4'd0, 0, 4'd0, 0, 4'd9, 1, 0), "w_r9",      0, 0, 0, 1);
    step(0, mk(4'd0, 0, 4'd0, 0, 4'd4, 1, 0), "w_r4_b",    0, 0, 0, 1);
    step(0, mk(4'd4, 1, 4'd4, 1, 4'd0, 0, 0), "youngest",  0, 1, 1, 1);
    step(0, mk(4'd4, 0, 4'd9, 1, 4'd0, 0, 0), "fwd_ent2",  0, 0, 3, 1);

    // flush beats a load-use stall and inserts nothing
    step(0, mk(4'd0, 0, 4'd0, 0, 4'd5, 1, 1), "lw_r5_b",   0, 0, 0, 1);
    tmp = mk(4'd0, 0, 4'd5, 1, 4'd0, 0, 0);
    tmp.flush = 1'b1;
    step(0, tmp,                              "flush",     0, 0, 1, 1);
    step(0, mk(4'd0, 0, 4'd5, 1, 4'd0, 0, 0), "post_flush",0, 0, 2, 1);

    // id_valid low: no stall, no insertion, selects still computed
    step(0, mk(4'd0, 0, 4'd0, 0, 4'd8, 1, 1), "lw_r8",     0, 0, 0, 1);
    tmp = mk(4'd8, 1, 4'd0, 0, 4'd0, 0, 0);
    tmp.valid = 1'b0;
    step(0, tmp,                              "inv_ld",    0, 1, 0, 1);
    step(0, tmp,                              "inv_noins", 0, 2, 0, 1);

    // stall-only instance: load-use and ALU RAW each stall three cycles
    step(1, mk(4'd0, 0, 4'd0, 0, 4'd5, 1, 1), "s_lw",      0, 0, 0, 0);
    step(1, mk(4'd0, 0, 4'd5, 1, 4'd0, 0, 0), "s_st0",     1, 0, 0, 0);
    step(1, mk(4'd0, 0, 4'd5, 1, 4'd0, 0, 0), "s_st1",     1, 0, 0, 1);
    step(1, mk(4'd0, 0, 4'd5, 1, 4'd0, 0, 0), "s_st2",     1, 0, 0, 2);
    step(1, mk(4'd0, 0, 4'd5, 1, 4'd0, 0, 0), "s_go",      0, 0, 0, 3);
    step(1, '0,                               "s_idle",    0, 0, 0, 3);
    step(1, mk(4'd0, 0, 4'd0, 0, 4'd3, 1, 0), "s_add",     0, 0, 0, 3);
    step(1, mk(4'd3, 1, 4'd0, 0, 4'd0, 0, 0), "s_alu0",    1, 0, 0, 3);
    step(1, mk(4'd3, 1, 4'd0, 0, 4'd0, 0, 0), "s_alu1",    1, 0, 0, 4);
    step(1, mk(4'd3, 1, 4'd0, 0, 4'd0, 0, 0), "s_alu2",    1, 0, 0, 5);
    step(1, mk(4'd3, 1, 4'd0, 0, 4'd0, 0, 0), "s_alu_go",  0, 0, 0, 6);

    // 2-bit counter saturates at 3 over five load-use stalls
    for (int i = 0; i < 5; i++) begin
      step(2, mk(4'd0, 0, 4'd0, 0, 4'd5, 1, 1), "sat_lw",    0, 0, 0, 16'((i < 3) ? i : 3));
      step(2, mk(4'd0, 0, 4'd5, 1, 4'd0, 0, 0), "sat_stall", 1, 0, 1, 16'((i < 3) ? i : 3));
      step(2, mk(4'd0, 0, 4'd5, 1, 4'd0, 0, 0), "sat_retry", 0, 0, 2, 16'((i + 1 < 3) ? i + 1 : 3));
    end

    // reset in the middle of a stall
    step(2, mk(4'd0, 0, 4'd0, 0, 4'd5, 1, 1), "mr_lw",     0, 0, 0, 3);
    step(2, mk(4'd0, 0, 4'd5, 1, 4'd0, 0, 0), "mr_stall",  1, 0, 1, 3);
    rst = 1'b1;
    step(2, mk(4'd0, 0, 4'd5, 1, 4'd0, 0, 0), "mr_in_rst", 0, 0, 0, 3);
    rst = 1'b0;
    step(2, mk(4'd0, 0, 4'd5, 1, 4'd0, 0, 0), "mr_after",  0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the WISC pipeline; sits beside the decode stage and replaces the fixed three-comparator hazard check.
- Tracks destination registers of in-flight instructions in a STAGES-deep shift scoreboard.
- Produces a decode stall, per-operand forward selects and a saturating stall counter.
- Supports stall-only and forwarding modes, and any pipeline depth.

Parameters:
- NUM_REGS, 16, architectural register count; register index width RW = $clog2(NUM_REGS).
- STAGES, 3, number of tracked stages past decode; entry 0 = ID/EX, STAGES-1 = MEM/WB.
- FWD_EN, 1, 1 = forwarding with load-use stall only; 0 = stall on any RAW match.
- ZERO_REG, 1, 1 = register 0 is hardwired zero and never causes a hazard.
- CNT_W, 16, width of stall_count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode holds a real instruction
- id_rs  in  RW  source register 1
- id_rt  in  RW  source register 2
- id_rs_used  in  1  rs is actually read
- id_rt_used  in  1  rt is actually read
- id_rd  in  RW  destination register
- id_reg_write  in  1  instruction writes id_rd
- id_mem_read  in  1  instruction is a load
- flush  in  1  branch/call/ret taken in EX; kills the decode instruction
- hazard  out  1  stall IF and IF/ID; insert bubble
- fwd_rs_sel  out  $clog2(STAGES+1)  0 = regfile, k+1 = forward from entry k
- fwd_rt_sel  out  $clog2(STAGES+1)  as fwd_rs_sel, for rt
- stall_count  out  CNT_W  saturating count of hazard cycles

Behaviour:
- Entry k holds {valid, rd, reg_write, mem_read}. An entry "matches" source s when: valid & reg_write & rd==s & the source is used & not (ZERO_REG & s==0).
- Reset (rst high at posedge): all entries valid=0 and stall_count=0.
- While rst is high, hazard=0 and both fwd selects are 0.
- Scoreboard update every cycle (not reset): entry k+1 <= entry k for k=0..STAGES-2, and the oldest entry is discarded.
  - Entry 0 is loaded from the id_* inputs when id_valid & ~hazard & ~flush.
  - Otherwise entry 0 is loaded with a bubble (valid=0).
- hazard, fwd_rs_sel and fwd_rt_sel are combinational from the id_* inputs and current entries; they take effect in the same cycle.
- FWD_EN=0: hazard = id_valid & ~flush & (any entry matches rs or rt). Forward selects are always 0.
- FWD_EN=1:
  - hazard = id_valid & ~flush & (entry 0 matches rs or rt & entry 0 mem_read). This is the load-use case.
  - fwd_x_sel = k+1 for the youngest (lowest k) matching entry, otherwise 0.
- Multiple matches: the youngest entry wins.
- flush has priority over hazard: hazard is forced to 0 and nothing is inserted.
- Stall duration:
  - Load-use stall resolves after exactly 1 cycle; the load moves to entry 1.
  - With FWD_EN=0, the stall lasts until no entry matches, at most STAGES cycles.
- stall_count increments by 1 on each cycle with hazard=1 and saturates at 2^CNT_W-1. It clears only on rst.
- rst mid-stall: the next cycle shows an empty scoreboard, hazard=0 and stall_count=0.
- id_valid=0: no hazard, no insertion; forward selects are still computed, but downstream ignores them.

Decomposition:
- Package wisc_pipe_pkg:
  - sb_entry_t struct: valid, rd, reg_write, mem_read.
  - Constant FWD_REGFILE = 0.
  - Function fwd_sel_w(STAGES).
- One sub-module, sb_match: combinational. Inputs are the source register index, its used flag and the entry array. It returns any_match, youngest_idx and youngest_is_load. It is instantiated once for rs and once for rt.

Test Plan:
- Reset, then issue ADD R3 (rd=3, reg_write=1); next cycle issue SUB reading rs=3 with FWD_EN=1 -> hazard=0, fwd_rs_sel=1; one cycle later a reader of R3 gets fwd_rs_sel=2.
- LW R5, then immediately a reader with rt=5 (FWD_EN=1) -> hazard=1 for exactly 1 cycle and stall_count=1; the retry gives hazard=0, fwd_rt_sel=2.
- Same program with FWD_EN=0, STAGES=3 -> hazard=1 for 3 consecutive cycles, then 0; stall_count=3.
- Producer writes R0, then a reader of R0 (ZERO_REG=1) -> hazard=0, fwd_rs_sel=0. Writes to R4 at entries 0 and 2 -> fwd selects 1 (youngest wins).
- Load-use stall with flush asserted in the same cycle -> hazard=0; the next cycle entry 0 is a bubble; stall_count unchanged.
- CNT_W=2, force 5 hazard cycles -> stall_count saturates at 3. Assert rst mid-stall -> next cycle stall_count=0, all selects 0, hazard=0.
